// File: rtl/forth.sv
// Minimal 16-bit two-stack Forth core: FETCH after reset or control transfer, then one word per EXEC cycle.
// Optional subroutine support (CALL words and ALU bit12 return) is enabled by defining FORTH_CALL_EN.
module forth #(
  parameter int PDEPTH = 16,
  parameter int RDEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  iaddr,
  input  logic [15:0] idata,
  output logic [7:0]  daddr,
  output logic [15:0] ddata_write,
  input  logic [15:0] ddata_read,
  output logic        dwrite
);

  localparam int PW = $clog2(PDEPTH);
  localparam int RW = $clog2(RDEPTH);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t        state, state_next;
  logic [15:0]   IP, TOS;
  logic [PW-1:0] PSP;
  logic [RW-1:0] RSP;
  logic [15:0]   pstack [PDEPTH];
  logic [15:0]   rstack [RDEPTH];

  logic [15:0]   N, R, alu, src, target;
  logic [15:0]   ip_next, tos_next, r_wdata;
  logic [PW-1:0] psp_next, p_waddr;
  logic [RW-1:0] rsp_next, r_waddr;
  logic          p_we, r_we;
  logic          unused_bits;

  assign N           = pstack[PSP];
  assign R           = rstack[RSP];
  assign iaddr       = IP[9:0];
  assign daddr       = TOS[7:0];
  assign ddata_write = N;
  assign target      = {3'b000, idata[12:0]};
  assign unused_bits = ^idata[12:10];

  always_comb begin
    alu = 16'h0000;
    case (idata[2:0])
      3'd0: alu = ~TOS;
      3'd1: alu = {TOS[15], TOS[15:1]};
      3'd2: alu = (TOS == 16'h0000) ? 16'hFFFF : 16'h0000;
      3'd3: alu = 16'h0000 - TOS;
      3'd4: alu = N & TOS;
      3'd5: alu = N | TOS;
      3'd6: alu = N ^ TOS;
      3'd7: alu = N + TOS;
      default: alu = 16'h0000;
    endcase
    src = alu;
    case (idata[7:6])
      2'b00: src = alu;
      2'b01: src = TOS;
      2'b10: src = N;
      2'b11: src = R;
      default: src = alu;
    endcase
  end

  // Every stack write pushes or overwrites with the old TOS; only CALL writes a different value.
  always_comb begin
    state_next = state;
    ip_next    = IP;
    tos_next   = TOS;
    psp_next   = PSP;
    rsp_next   = RSP;
    p_we       = 1'b0;
    p_waddr    = PSP;
    r_we       = 1'b0;
    r_waddr    = RSP;
    r_wdata    = TOS;
    dwrite     = 1'b0;
    if (state == FETCH) begin
      state_next = EXEC;
    end else begin
      ip_next = IP + 16'd1;
      if (!idata[15]) begin
        psp_next = PSP + 1'b1;
        p_we     = 1'b1;
        p_waddr  = PSP + 1'b1;
        tos_next = {1'b0, idata[14:0]};
      end else begin
        case (idata[14:13])
          2'b00: begin
            ip_next    = target;
            state_next = FETCH;
          end
          2'b01: begin
            tos_next = N;
            psp_next = PSP - 1'b1;
            if (TOS == 16'h0000) begin
              ip_next    = target;
              state_next = FETCH;
            end
          end
          2'b10: begin
`ifdef FORTH_CALL_EN
            // Return address is the word following the CALL.
            rsp_next   = RSP + 1'b1;
            r_we       = 1'b1;
            r_waddr    = RSP + 1'b1;
            r_wdata    = IP + 16'd1;
            ip_next    = target;
            state_next = FETCH;
`endif
          end
          default: begin
            tos_next = idata[9] ? ddata_read : src;
            dwrite   = idata[8];
            case (idata[3:2])
              2'b01: psp_next = PSP - 1'b1;
              2'b10: p_we = 1'b1;
              2'b11: begin
                psp_next = PSP + 1'b1;
                p_we     = 1'b1;
                p_waddr  = PSP + 1'b1;
              end
              default: ;
            endcase
            case (idata[5:4])
              2'b01: rsp_next = RSP - 1'b1;
              2'b11: begin
                rsp_next = RSP + 1'b1;
                r_we     = 1'b1;
                r_waddr  = RSP + 1'b1;
              end
              default: ;
            endcase
`ifdef FORTH_CALL_EN
            if (idata[12]) begin
              ip_next    = R;
              rsp_next   = rsp_next - 1'b1;
              state_next = FETCH;
            end
`endif
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      IP    <= 16'h0000;
      TOS   <= 16'h0000;
      PSP   <= '0;
      RSP   <= '0;
    end else begin
      state <= state_next;
      IP    <= ip_next;
      TOS   <= tos_next;
      PSP   <= psp_next;
      RSP   <= rsp_next;
    end
  end

  // Stack contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && p_we) pstack[p_waddr] <= TOS;
    if (!reset && r_we) rstack[r_waddr] <= r_wdata;
  end

endmodule

// File: tb/tb_forth.sv
// Directed testbench for the forth core: drives one instruction word per EXEC cycle and probes internal state.
module tb_forth;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  iaddr;
  logic [15:0] idata;
  logic [7:0]  daddr;
  logic [15:0] ddata_write;
  logic [15:0] ddata_read;
  logic        dwrite;

  int vectors = 0;
  int miscompares = 0;

  forth dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .daddr(daddr),
    .ddata_write(ddata_write), .ddata_read(ddata_read), .dwrite(dwrite)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    idata = 16'hE040;
    ddata_read = 16'h0000;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic start();
    do_reset();
    @(posedge clk); #1;
  endtask

  task automatic exec(input logic [15:0] w);
    idata = w;
    @(posedge clk); #1;
  endtask

  task automatic start_at_100();
    do_reset();
    force dut.IP = 16'h0100;
    @(posedge clk); #1;
    release dut.IP;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (dut.IP !== 16'h0000) begin $display("FAIL reset_ip got %h want 0000", dut.IP); miscompares++; end
    vectors++; if (dut.PSP !== 4'h0) begin $display("FAIL reset_psp got %h want 0", dut.PSP); miscompares++; end
    vectors++; if (dut.RSP !== 4'h0) begin $display("FAIL reset_rsp got %h want 0", dut.RSP); miscompares++; end
    vectors++; if (dut.TOS !== 16'h0000) begin $display("FAIL reset_tos got %h want 0000", dut.TOS); miscompares++; end
    vectors++; if (dut.state !== 1'b0) begin $display("FAIL reset_state got %b want 0", dut.state); miscompares++; end
    vectors++; if (dwrite !== 1'b0) begin $display("FAIL reset_dwrite got %b want 0", dwrite); miscompares++; end
    exec(16'h1234);
    vectors++; if (dut.state !== 1'b1) begin $display("FAIL fetch_state got %b want 1", dut.state); miscompares++; end
    vectors++; if (dut.TOS !== 16'h0000 || dut.IP !== 16'h0000) begin $display("FAIL fetch_ignores got tos=%h ip=%h want 0000/0000", dut.TOS, dut.IP); miscompares++; end
  endtask

  task automatic test_literal();
    start_at_100();
    exec(16'h7FFF);
    vectors++; if (dut.IP !== 16'h0101) begin $display("FAIL lit_ip got %h want 0101", dut.IP); miscompares++; end
    vectors++; if (dut.PSP !== 4'h1 || dut.RSP !== 4'h0) begin $display("FAIL lit_ptrs got psp=%h rsp=%h want 1/0", dut.PSP, dut.RSP); miscompares++; end
    vectors++; if (dut.TOS !== 16'h7FFF) begin $display("FAIL lit_tos got %h want 7FFF", dut.TOS); miscompares++; end
    start_at_100();
    exec(16'hE040);
    vectors++; if (dut.IP !== 16'h0101 || dut.PSP !== 4'h0 || dut.TOS !== 16'h0000) begin
      $display("FAIL nop got ip=%h psp=%h tos=%h want 0101/0/0000", dut.IP, dut.PSP, dut.TOS); miscompares++; end
    start();
    exec(16'h1000); exec(16'h2000);
    vectors++; if (dut.PSP !== 4'h2 || dut.TOS !== 16'h2000) begin $display("FAIL two_lit got psp=%h tos=%h want 2/2000", dut.PSP, dut.TOS); miscompares++; end
    vectors++; if (dut.pstack[dut.PSP] !== 16'h1000) begin $display("FAIL two_lit_n got %h want 1000", dut.pstack[dut.PSP]); miscompares++; end
  endtask

  task automatic test_unary();
    start();
    exec(16'h7FFF); exec(16'hE000); exec(16'hE001);
    vectors++; if (dut.TOS !== 16'hC000 || dut.PSP !== 4'h1) begin $display("FAIL not_asr got tos=%h psp=%h want C000/1", dut.TOS, dut.PSP); miscompares++; end
    start();
    exec(16'h0000); exec(16'hE002);
    vectors++; if (dut.TOS !== 16'hFFFF) begin $display("FAIL zero_eq got %h want FFFF", dut.TOS); miscompares++; end
    exec(16'hE002);
    vectors++; if (dut.TOS !== 16'h0000) begin $display("FAIL zero_eq_false got %h want 0000", dut.TOS); miscompares++; end
    start();
    exec(16'h0001); exec(16'hE003);
    vectors++; if (dut.TOS !== 16'hFFFF) begin $display("FAIL negate got %h want FFFF", dut.TOS); miscompares++; end
  endtask

  task automatic test_binary();
    logic [15:0] want;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: want = 16'h1230;
        1: want = 16'h567C;
        2: want = 16'h444C;
        default: want = 16'h68AC;
      endcase
      start();
      exec(16'h1234); exec(16'h5678); exec(16'hE004 + 16'(i));
      vectors++; if (dut.TOS !== want || dut.PSP !== 4'h1) begin
        $display("FAIL binop%0d got tos=%h psp=%h want %h/1", i, dut.TOS, dut.PSP, want); miscompares++; end
    end
  endtask

  task automatic test_stack_words();
    start();
    exec(16'h1234); exec(16'h5678); exec(16'hE088);
    vectors++; if (dut.TOS !== 16'h1234 || dut.pstack[dut.PSP] !== 16'h5678 || dut.PSP !== 4'h2) begin
      $display("FAIL swap got tos=%h n=%h psp=%h want 1234/5678/2", dut.TOS, dut.pstack[dut.PSP], dut.PSP); miscompares++; end
    start();
    exec(16'h1234); exec(16'hE04C);
    vectors++; if (dut.TOS !== 16'h1234 || dut.pstack[dut.PSP] !== 16'h1234 || dut.PSP !== 4'h2) begin
      $display("FAIL dup got tos=%h n=%h psp=%h want 1234/1234/2", dut.TOS, dut.pstack[dut.PSP], dut.PSP); miscompares++; end
    start();
    exec(16'h1234); exec(16'h5678); exec(16'h0ABC); exec(16'hE0B4);
    vectors++; if (dut.PSP !== 4'h2 || dut.RSP !== 4'h1 || dut.TOS !== 16'h5678) begin
      $display("FAIL to_r got psp=%h rsp=%h tos=%h want 2/1/5678", dut.PSP, dut.RSP, dut.TOS); miscompares++; end
    vectors++; if (dut.rstack[1] !== 16'h0ABC) begin $display("FAIL to_r_stack got %h want 0ABC", dut.rstack[1]); miscompares++; end
    exec(16'hE084); exec(16'hE0DC);
    vectors++; if (dut.RSP !== 4'h0 || dut.TOS !== 16'h0ABC || dut.pstack[dut.PSP] !== 16'h1234 || dut.IP !== 16'h0006) begin
      $display("FAIL r_from got rsp=%h tos=%h n=%h ip=%h want 0/0ABC/1234/0006", dut.RSP, dut.TOS, dut.pstack[dut.PSP], dut.IP); miscompares++; end
  endtask

  task automatic test_memory();
    start();
    exec(16'h1234); exec(16'h0042);
    idata = 16'hE140; #1;
    vectors++; if (dwrite !== 1'b1 || daddr !== 8'h42 || ddata_write !== 16'h1234) begin
      $display("FAIL store got dwrite=%b daddr=%h data=%h want 1/42/1234", dwrite, daddr, ddata_write); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (dut.TOS !== 16'h0042 || dut.PSP !== 4'h2) begin $display("FAIL store_state got tos=%h psp=%h want 0042/2", dut.TOS, dut.PSP); miscompares++; end
    ddata_read = 16'hBEEF;
    idata = 16'hE200; #1;
    vectors++; if (dwrite !== 1'b0) begin $display("FAIL load_dwrite got %b want 0", dwrite); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (dut.TOS !== 16'hBEEF || dut.PSP !== 4'h2) begin $display("FAIL load got tos=%h psp=%h want BEEF/2", dut.TOS, dut.PSP); miscompares++; end
  endtask

  task automatic test_branch();
    start();
    exec(16'h8300);
    vectors++; if (dut.IP !== 16'h0300 || dut.PSP !== 4'h0 || dut.state !== 1'b0) begin
      $display("FAIL branch got ip=%h psp=%h state=%b want 0300/0/0", dut.IP, dut.PSP, dut.state); miscompares++; end
    exec(16'h7FFF);
    vectors++; if (dut.TOS !== 16'h0000 || dut.IP !== 16'h0300 || dut.state !== 1'b1) begin
      $display("FAIL branch_fetch got tos=%h ip=%h state=%b want 0000/0300/1", dut.TOS, dut.IP, dut.state); miscompares++; end
    start();
    exec(16'h0000); exec(16'hA300);
    vectors++; if (dut.IP !== 16'h0300 || dut.PSP !== 4'h0 || dut.state !== 1'b0) begin
      $display("FAIL zbranch_taken got ip=%h psp=%h state=%b want 0300/0/0", dut.IP, dut.PSP, dut.state); miscompares++; end
    start();
    exec(16'h0001); exec(16'hA300);
    vectors++; if (dut.IP !== 16'h0002 || dut.PSP !== 4'h0 || dut.TOS !== 16'h0000 || dut.state !== 1'b1) begin
      $display("FAIL zbranch_not got ip=%h psp=%h tos=%h state=%b want 0002/0/0000/1", dut.IP, dut.PSP, dut.TOS, dut.state); miscompares++; end
  endtask

  task automatic test_wrap();
    start();
    exec(16'hE084);
    vectors++; if (dut.PSP !== 4'hF) begin $display("FAIL psp_wrap got %h want F", dut.PSP); miscompares++; end
    exec(16'hE0DC);
    vectors++; if (dut.RSP !== 4'hF || dut.PSP !== 4'h0) begin $display("FAIL rsp_wrap got rsp=%h psp=%h want F/0", dut.RSP, dut.PSP); miscompares++; end
  endtask

  task automatic test_call();
    start();
    exec(16'h0005); exec(16'hC123);
`ifdef FORTH_CALL_EN
    vectors++; if (dut.IP !== 16'h0123 || dut.RSP !== 4'h1 || dut.rstack[1] !== 16'h0002 || dut.state !== 1'b0) begin
      $display("FAIL call got ip=%h rsp=%h ret=%h state=%b want 0123/1/0002/0", dut.IP, dut.RSP, dut.rstack[1], dut.state); miscompares++; end
    exec(16'hE040); exec(16'hF040);
    vectors++; if (dut.IP !== 16'h0002 || dut.RSP !== 4'h0 || dut.state !== 1'b0) begin
      $display("FAIL return got ip=%h rsp=%h state=%b want 0002/0/0", dut.IP, dut.RSP, dut.state); miscompares++; end
`else
    vectors++; if (dut.IP !== 16'h0002 || dut.RSP !== 4'h0 || dut.TOS !== 16'h0005 || dut.state !== 1'b1) begin
      $display("FAIL call_off got ip=%h rsp=%h tos=%h state=%b want 0002/0/0005/1", dut.IP, dut.RSP, dut.TOS, dut.state); miscompares++; end
    exec(16'hF040);
    vectors++; if (dut.IP !== 16'h0003 || dut.RSP !== 4'h0 || dut.state !== 1'b1) begin
      $display("FAIL return_off got ip=%h rsp=%h state=%b want 0003/0/1", dut.IP, dut.RSP, dut.state); miscompares++; end
`endif
  endtask

  initial begin
    reset = 1'b1;
    idata = 16'hE040;
    ddata_read = 16'h0000;
    test_reset();
    test_literal();
    test_unary();
    test_binary();
    test_stack_words();
    test_memory();
    test_branch();
    test_wrap();
    test_call();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
